// File: rtl/security_pkg.sv
// security_pkg
// Shared definitions for the security controller input path.
//   CH_*        : bit positions of each sensor inside RAW_IN / CLEAN_OUT
//   CLK_HZ      : nominal system clock frequency
//   db_state_t  : per-channel debounce state
package security_pkg;

    localparam int CH_WINDOW = 0;
    localparam int CH_DOOR   = 1;
    localparam int CH_KEY0   = 2;
    localparam int CH_KEY1   = 3;

    localparam int CLK_HZ = 125_000_000;

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } db_state_t;

endpackage

// File: rtl/db_channel.sv
// db_channel
// One input channel: 2-FF synchronizer, debounce counter, clean level
// register and one-cycle edge pulses.
// Build option: DEBOUNCE_BYPASS_EN makes the clean level follow the
// synchronized input every cycle (counter held at 0).
// Ports:
//   CLK   in   system clock
//   RST   in   synchronous active-high reset
//   raw   in   asynchronous raw level
//   tick  in   one-cycle sample tick
//   clean out  debounced level (registered)
//   rise  out  one-cycle pulse on clean 0->1
//   fall  out  one-cycle pulse on clean 1->0
//
// state   | meaning
// --------+----------------------------------------------------------
// STABLE  | synchronized input equals clean; counter held at 0
// PENDING | synchronized input differs; counter advances on each tick
module db_channel
    import security_pkg::*;
#(
    parameter int DB_TICKS = 20
) (
    input  logic CLK,
    input  logic RST,
    input  logic raw,
    input  logic tick,
    output logic clean,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(DB_TICKS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_TICKS - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;
    db_state_t     state;

    // State is a pure function of the sync output vs. the clean level,
    // so any cycle where the mismatch disappears clears the count.
    assign state = (s2 != clean) ? PENDING : STABLE;

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            clean <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            s1   <= raw;
            s2   <= s1;
            rise <= 1'b0;
            fall <= 1'b0;
`ifdef DEBOUNCE_BYPASS_EN
            cnt   <= '0;
            clean <= s2;
            rise  <= (state == PENDING) &  s2;
            fall  <= (state == PENDING) & ~s2;
`else
            case (state)
                STABLE: cnt <= '0;
                PENDING: begin
                    if (tick) begin
                        if (cnt == CNT_LAST) begin
                            clean <= s2;
                            cnt   <= '0;
                            rise  <=  s2;
                            fall  <= ~s2;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: cnt <= '0;
            endcase
`endif
        end
    end

`ifdef DEBOUNCE_BYPASS_EN
    logic [CW:0] unused_bypass;
    assign unused_bypass = {tick, cnt};
`endif

endmodule

// File: rtl/input_debounce.sv
// input_debounce
// Synchronizes and debounces the raw KEY[1:0]/DOOR/WINDOW levels feeding
// the security FSM, and produces one-cycle rise/fall pulses per channel.
// Build option: DEBOUNCE_BYPASS_EN (clean levels follow the synchronized
// inputs with no debounce; tick generator keeps running).
// Ports:
//   CLK        in   system clock
//   RST        in   synchronous active-high reset
//   RAW_IN     in   raw levels {KEY1, KEY0, DOOR, WINDOW}
//   CLEAN_OUT  out  debounced levels
//   RISE       out  per-channel one-cycle 0->1 pulse
//   FALL       out  per-channel one-cycle 1->0 pulse
//   TICK       out  one-cycle sample tick every TICK_DIV cycles
module input_debounce
    import security_pkg::*;
#(
    parameter int N        = 4,
    parameter int TICK_DIV = 125_000,
    parameter int DB_TICKS = 20
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [N-1:0] RAW_IN,
    output logic [N-1:0] CLEAN_OUT,
    output logic [N-1:0] RISE,
    output logic [N-1:0] FALL,
    output logic         TICK
);

    localparam int TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic [TW-1:0] tick_cnt;

    // TICK is registered off the terminal count, so it lands one cycle
    // after the counter shows TICK_DIV-1.
    always_ff @(posedge CLK) begin
        if (RST) begin
            tick_cnt <= '0;
            TICK     <= 1'b0;
        end else begin
            TICK <= (tick_cnt == TICK_LAST);
            if (tick_cnt == TICK_LAST) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_ch
        db_channel #(
            .DB_TICKS(DB_TICKS)
        ) u_ch (
            .CLK  (CLK),
            .RST  (RST),
            .raw  (RAW_IN[g]),
            .tick (TICK),
            .clean(CLEAN_OUT[g]),
            .rise (RISE[g]),
            .fall (FALL[g])
        );
    end

endmodule

// File: doc/input_debounce.md
Name: input_debounce

Overview:
- Input conditioning stage directly upstream of the security FSM.
- Takes raw asynchronous switch/button levels (KEY[1:0], DOOR, WINDOW), synchronizes them to CLK, and debounces each one.
- Delivers clean levels plus one-cycle rise/fall pulses to the FSM.
- Glitches shorter than the debounce window never reach the FSM.

Parameters:
- N, 4, number of input channels; bit map RAW_IN[3:2]=KEY[1:0], RAW_IN[1]=DOOR, RAW_IN[0]=WINDOW.
- TICK_DIV, 125_000, CLK cycles per sample tick (1 ms at 125 MHz); must be >= 2.
- DB_TICKS, 20, consecutive mismatching ticks required before a clean level changes; must be >= 1.

Ports:
- CLK  input  1  system clock; sole clock domain.
- RST  input  1  reset, synchronous, active-high.
- RAW_IN  input  N  raw asynchronous levels from board switches/sensors.
- CLEAN_OUT  output  N  debounced levels, registered; feeds KEY/DOOR/WINDOW of the FSM.
- RISE  output  N  one-cycle pulse per channel when CLEAN_OUT goes 0->1.
- FALL  output  N  one-cycle pulse per channel when CLEAN_OUT goes 1->0.
- TICK  output  1  one-cycle sample-tick pulse, exported for reuse/debug.

Behaviour:
- Reset: on a CLK edge with RST=1, the following are all cleared to 0:
  - both sync stages;
  - tick counter;
  - every channel counter;
  - CLEAN_OUT, RISE, FALL, TICK.
- Reset mid-debounce discards partial counts.
- A channel held at 1 through reset produces RISE after a full debounce window following release of RST.
- Synchronizer: 2 flip-flops per channel (s1 <= RAW_IN; s2 <= s1). Only s2 is used downstream.
- Tick generator:
  - Counter width $clog2(TICK_DIV); counts 0..TICK_DIV-1, then wraps to 0.
  - TICK is registered; it is 1 for exactly one cycle, in the cycle after the counter value TICK_DIV-1.
  - Period is exactly TICK_DIV cycles.
  - First TICK occurs TICK_DIV cycles after RST deasserts.
- Per-channel FSM has two states:
  - STABLE (s2 == CLEAN_OUT): channel counter is held at 0.
  - PENDING (s2 != CLEAN_OUT): counter increments on each TICK.
- PENDING -> STABLE without change: if s2 returns to equal CLEAN_OUT on any cycle, the counter clears to 0 that cycle. The mismatch must be continuous.
- PENDING -> commit:
  - Condition: TICK=1, mismatch present, and counter == DB_TICKS-1.
  - Next edge: CLEAN_OUT <= s2, counter <= 0, and RISE or FALL asserts for that one cycle.
  - The pulse is aligned with the first cycle of the new CLEAN_OUT value.
- Counter width: $clog2(DB_TICKS+1). The counter never exceeds DB_TICKS-1, so it cannot wrap.
- Latency from a RAW_IN step to CLEAN_OUT: between (DB_TICKS-1)*TICK_DIV+3 and DB_TICKS*TICK_DIV+3 cycles, depending on tick phase.
- Simultaneous events:
  - Channels are fully independent; several may commit on the same cycle, each asserting its own pulse.
  - A mismatch that clears on the same cycle as the committing TICK does not commit; the clear wins.
- RISE and FALL for one channel are never both 1. Each pulse lasts exactly one cycle.
- All outputs are registered. There are no combinational paths from RAW_IN to outputs.

Optional Feature:
- Macro: DEBOUNCE_BYPASS_EN.
- When defined:
  - Debounce counters are tied to 0.
  - CLEAN_OUT <= s2 every cycle (latency 3 cycles from RAW_IN).
  - RISE/FALL are still generated on each CLEAN_OUT change.
  - TICK still runs.
  - Intended for fast system simulation.
- When undefined: full debounce as above.

Decomposition:
- Shared package security_pkg holds:
  - channel index constants CH_WINDOW=0, CH_DOOR=1, CH_KEY0=2, CH_KEY1=3;
  - default CLK_HZ=125_000_000;
  - the debounce-state enum {STABLE, PENDING}.
- Sub-module db_channel: one channel's 2-FF sync, counter, state, clean register and edge pulses.
  - Inputs: CLK, RST, raw, tick.
  - Instantiated N times by a generate loop.
- Tick generator stays in the top level.

Test Plan (TICK_DIV=4, DB_TICKS=3 unless noted):
- Reset: RST=1 for 2 cycles with RAW_IN=4'b1111 -> CLEAN_OUT=0, RISE=FALL=TICK=0. After release, CLEAN_OUT=4'b1111 and RISE=4'b1111 for one cycle within 9..15 cycles.
- Clean step: RAW_IN[1] 0->1 and held -> CLEAN_OUT[1]=1 after 3 TICKs of mismatch. RISE[1] is a single one-cycle pulse aligned with the change. Other bits are unchanged.
- Glitch reject: RAW_IN[0] high for 2 TICK periods, then low -> CLEAN_OUT[0] stays 0, and RISE/FALL stay 0.
- Chatter: RAW_IN[2] toggles every 5 cycles for 60 cycles, then settles at 1 -> no pulse during chatter. Exactly one RISE[2] after the settle plus the debounce window.
- Simultaneous: RAW_IN 4'b0000 -> 4'b1100 on the same cycle -> CLEAN_OUT[3:2] change on the same cycle, and RISE=4'b1100 for one cycle.
- Mid-op reset: assert RST while channel 3 has count 2 -> counter is 0 after reset. The full 3-TICK window is required again before RISE[3]. With DEBOUNCE_BYPASS_EN: RAW_IN step -> CLEAN_OUT follows in 3 cycles with one pulse.
